// File: rtl/apb_pkg.sv
// Shared APB definitions: bus FSM encoding (also used by the register slaves)
// and default widths for the two-requester APB master.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_NUM_SLAVES = 4;
  localparam int APB_SEL_BITS   = 2;
  localparam int APB_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the valids and the
// last-granted bit, pointer advanced only when the grant is actually taken.
module apb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last;

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Reset value 1 makes requester 0 the winner of the first contended grant.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last <= 1'b1;
    else if (i_accept) r_last <= o_grant[1];
  end

endmodule

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin command intake, slave decode from the
// address MSBs, IDLE/SETUP/ACCESS sequencing with a wait-state timeout.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int NUM_SLAVES = APB_NUM_SLAVES,
  parameter int SEL_BITS   = APB_SEL_BITS,
  parameter int TIMEOUT    = APB_TIMEOUT
) (
  input  logic                    pclk,
  input  logic                    prst_n,
  input  logic [1:0]              rq_valid,
  input  logic [1:0]              rq_write,
  input  logic [2*ADDR_WIDTH-1:0] rq_addr,
  input  logic [2*DATA_WIDTH-1:0] rq_wdata,
  output logic [1:0]              rq_ready,
  output logic [1:0]              rs_valid,
  output logic [DATA_WIDTH-1:0]   rs_rdata,
  output logic                    rs_err,
  output logic [NUM_SLAVES-1:0]   psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT);

  apb_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_write;
  logic                  r_id;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_rs_valid;
  logic [DATA_WIDTH-1:0] r_rs_rdata;
  logic                  r_rs_err;

  logic [1:0]            w_grant;
  logic                  w_accept;
  logic                  w_gnt_id;
  logic [ADDR_WIDTH-1:0] w_addr_in;
  logic [SEL_BITS-1:0]   w_sel_in;
  logic                  w_miss;
  logic [SEL_BITS-1:0]   w_idx;
  logic                  w_timeout;

  assign w_accept  = (r_state == IDLE) && (|rq_valid);
  assign w_gnt_id  = w_grant[1];
  assign w_addr_in = w_gnt_id ? rq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : rq_addr[ADDR_WIDTH-1:0];
  assign w_sel_in  = w_addr_in[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_miss    = int'(w_sel_in) >= NUM_SLAVES;
  assign w_idx     = r_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  apb_rr_arb2 u_arb (
    .clk      (pclk),
    .rst_n    (prst_n),
    .i_valid  (rq_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_id       <= 1'b0;
      r_cnt      <= '0;
      r_rs_valid <= 2'b00;
      r_rs_rdata <= '0;
      r_rs_err   <= 1'b0;
    end else begin
      r_rs_valid <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id <= w_gnt_id;
            if (w_miss) begin
              // Unmapped slave: answer with an error straight from IDLE.
              r_rs_valid <= w_grant;
              r_rs_rdata <= '0;
              r_rs_err   <= 1'b1;
            end else begin
              r_addr  <= w_addr_in;
              r_wdata <= w_gnt_id ? rq_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : rq_wdata[DATA_WIDTH-1:0];
              r_write <= rq_write[w_gnt_id];
              r_state <= SETUP;
            end
          end
        end
        SETUP: begin
          r_cnt   <= '0;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            r_rs_valid <= r_id ? 2'b10 : 2'b01;
            r_rs_rdata <= r_write ? '0 : prdata;
            r_rs_err   <= pslverr;
            r_cnt      <= '0;
            r_state    <= IDLE;
          end else if (w_timeout) begin
            r_rs_valid <= r_id ? 2'b10 : 2'b01;
            r_rs_rdata <= '0;
            r_rs_err   <= 1'b1;
            r_cnt      <= '0;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // psel/penable decode straight from the state so an async reset drops them at once.
  always_comb begin
    psel = '0;
    for (int s = 0; s < NUM_SLAVES; s++)
      psel[s] = (r_state != IDLE) && (int'(w_idx) == s);
  end

  assign penable  = (r_state == ACCESS);
  assign pwrite   = r_write;
  assign paddr    = r_addr;
  assign pwdata   = r_wdata;
  assign rq_ready = (r_state == IDLE) ? w_grant : 2'b00;
  assign rs_valid = r_rs_valid;
  assign rs_rdata = r_rs_rdata;
  assign rs_err   = r_rs_err;

endmodule
